vt_video_ctl: RTL
=================

Name: vt_video_ctl

Overview:
- Wishbone control/status slave that drives the text VGA adapter's control inputs: `cursor`, `lmode`, `cursor_on`, `cursor_type` and `flash`.
- Holds the CSR bits and the cursor address. Converts row/column cursor writes into a linear VRAM address.
- Generates the flash (blink) timebase for blinking characters and the blinking cursor.
- Sits on the same bus and clock as the video buffer; its outputs wire directly to the adapter's control inputs.

Parameters:
- TICK_DIV, 50000, wb_clk_i cycles per millisecond tick (50 MHz).
- FLASH_DEF, 250, reset value of the flash half-period in ms ticks.
- COLS, 80, characters per text row (row stride in VRAM).

Ports:
- wb_clk_i  in  1  bus/system clock; the only clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_adr_i  in  16  byte address; [2:1] selects the register.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data, registered.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  2  byte lane enables: [0] = low byte, [1] = high byte.
- wb_ack_o  out  1  acknowledge.
- cursor  out  13  linear cursor address into VRAM.
- lmode  out  1  0 = 24-row mode, 1 = 38-row mode.
- cursor_on  out  1  cursor visible this instant.
- cursor_type  out  1  0 = underline, 1 = block.
- flash  out  1  blink phase; 1 = blinking characters visible.

Behaviour:
- Reset: interface is one clock; reset is asynchronous and active-high, port names wb_clk_i and wb_rst_i. On assertion:
  - wb_ack_o=0, wb_dat_o=0.
  - CSR: lmode=0, cursor_en=1, cursor_type=0, blink_en=1.
  - cursor=0, rowcol=0, period=FLASH_DEF.
  - tick and flash counters = 0, flash=1.
- Handshake:
  - wb_ack_o <= cyc & stb & ~wb_ack_o, so a held strobe acks every other clock.
  - Read data and write effects take place on the clock where cyc & stb & ~wb_ack_o.
  - Byte lanes gate writes per wb_sel_i; wb_sel_i is ignored on reads.
- Register map (wb_adr_i[2:1]):
  - 0 CSR, RW:
    - [0] lmode, [1] cursor_en, [2] cursor_type, [3] blink_en.
    - [14:4] read 0.
    - [15] current flash value, read-only.
  - 1 CURSOR, RW: [12:0] linear address; [15:13] read 0, ignored on write.
  - 2 PERIOD, RW: [7:0] flash half-period in ms; [15:8] read 0.
  - 3 ROWCOL, RW: [6:0] col, [13:8] row; reads return the last value written here.
- ROWCOL write:
  - Effective row/col is merged from wb_sel_i and the stored value.
  - col is clamped to COLS-1 (79).
  - row is clamped to 23 if lmode=0, 37 if lmode=1, using the lmode value before this write.
  - Clamped values are stored.
  - cursor <= row*COLS + col (shift-add: row<<6 + row<<4 + col), updated 1 clock after the ack edge; 13-bit result, no overflow (max 3039).
- CURSOR write overrides cursor directly and does not alter the ROWCOL storage. The last write wins.
- Flash timebase:
  - tick counter counts 0..TICK_DIV-1 and pulses a tick at wrap.
  - The ms counter increments on each tick. When it reaches period-1 it clears and flash toggles.
  - period=0: flash held 1, ms counter held 0.
  - A PERIOD write clears both counters and sets flash=1 on the same edge.
- cursor_on = cursor_en & (~blink_en | flash), combinational from registers.
- lmode and cursor_type are direct CSR bits.
- Reset mid-transaction: ack drops immediately; the pending write is discarded.

Test Plan:
- Reset release -> cursor=0, lmode=0, cursor_on=1, flash=1, wb_ack_o=0; read CSR returns 0x800A.
- Write ROWCOL=0x0205 (row 2, col 5), sel=11 -> ack 1 clk later; cursor=165 one clock after the ack edge; read ROWCOL=0x0205.
- lmode=0, write ROWCOL=0x3F7F -> clamped to row 23 col 79, cursor=1919. Repeat with lmode=1 -> row 37, cursor=3039.
- TICK_DIV=4, write PERIOD=3 -> flash toggles every 12 clocks. blink_en=1 makes cursor_on follow flash; blink_en=0 gives cursor_on=1 constant. PERIOD=0 -> flash stuck 1.
- Write CURSOR=0x1ABC with sel=01 from cursor 0 -> cursor=0x00BC. Then sel=10 data 0xFF00 -> cursor=0x1FBC (bits 15:13 dropped).
- Hold cyc/stb for 6 clocks -> ack pattern 0,1,0,1,0,1. Assert wb_rst_i while ack=1 -> ack=0 and flash=1 asynchronously.

Source files
------------

// File: rtl/vt_video_ctl.sv
// Wishbone control/status slave for the text VGA adapter: CSR bits, cursor
// address (direct or row/column), and the flash blink timebase.
module vt_video_ctl #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned FLASH_DEF = 250,
  parameter int unsigned COLS      = 80
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [12:0] cursor,
  output logic        lmode,
  output logic        cursor_on,
  output logic        cursor_type,
  output logic        flash
);

  localparam int unsigned CW = 13;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [6:0]    COL_MAX    = 7'(COLS - 1);
  localparam logic [5:0]    ROW_MAX_24 = 6'd23;
  localparam logic [5:0]    ROW_MAX_38 = 6'd37;

  localparam logic [1:0] REG_CSR    = 2'd0;
  localparam logic [1:0] REG_CURSOR = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_ROWCOL = 2'd3;

  logic          r_ack;
  logic [15:0]   r_dat;
  logic          r_lmode;
  logic          r_cursor_en;
  logic          r_cursor_type;
  logic          r_blink_en;
  logic [CW-1:0] r_cursor;
  logic [6:0]    r_col;
  logic [5:0]    r_row;
  logic          r_rc_pend;
  logic [7:0]    r_period;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_ms;
  logic          r_flash;

  logic          w_acc;
  logic          w_wr;
  logic [1:0]    w_reg;
  logic [15:0]   w_rd;
  logic [6:0]    w_col_m;
  logic [5:0]    w_row_m;
  logic [5:0]    w_row_max;
  logic [6:0]    w_col_c;
  logic [5:0]    w_row_c;
  logic [CW-1:0] w_lin;
  logic          w_tick;
  logic          w_unused;

  assign w_acc = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr  = w_acc & wb_we_i;
  assign w_reg = wb_adr_i[2:1];

  // Row/column merge with stored value, then clamp against the current mode
  assign w_col_m   = wb_sel_i[0] ? wb_dat_i[6:0]  : r_col;
  assign w_row_m   = wb_sel_i[1] ? wb_dat_i[13:8] : r_row;
  assign w_row_max = r_lmode ? ROW_MAX_38 : ROW_MAX_24;
  assign w_col_c   = (w_col_m > COL_MAX)   ? COL_MAX   : w_col_m;
  assign w_row_c   = (w_row_m > w_row_max) ? w_row_max : w_row_m;
  assign w_lin     = CW'(r_row) * CW'(COLS) + CW'(r_col);

  assign w_tick   = (r_tick == TICK_LAST);
  assign w_unused = ^{wb_adr_i[15:3], wb_adr_i[0], wb_dat_i[15:14]};

  always_comb begin
    w_rd = 16'd0;
    case (w_reg)
      REG_CSR:    w_rd = {r_flash, 11'd0, r_blink_en, r_cursor_type, r_cursor_en, r_lmode};
      REG_CURSOR: w_rd = {3'd0, r_cursor};
      REG_PERIOD: w_rd = {8'd0, r_period};
      default:    w_rd = {2'd0, r_row, 1'b0, r_col};
    endcase
  end

  // Bus handshake and registered read data
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 16'd0;
    end else begin
      r_ack <= w_acc;
      if (w_acc && !wb_we_i) r_dat <= w_rd;
    end
  end

  // Control registers; a row/column write lands in the cursor one clock later
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_lmode       <= 1'b0;
      r_cursor_en   <= 1'b1;
      r_cursor_type <= 1'b0;
      r_blink_en    <= 1'b1;
      r_cursor      <= '0;
      r_col         <= 7'd0;
      r_row         <= 6'd0;
      r_rc_pend     <= 1'b0;
      r_period      <= 8'(FLASH_DEF);
    end else begin
      r_rc_pend <= 1'b0;
      if (r_rc_pend) r_cursor <= w_lin;
      if (w_wr) begin
        case (w_reg)
          REG_CSR: begin
            if (wb_sel_i[0]) begin
              r_lmode       <= wb_dat_i[0];
              r_cursor_en   <= wb_dat_i[1];
              r_cursor_type <= wb_dat_i[2];
              r_blink_en    <= wb_dat_i[3];
            end
          end
          REG_CURSOR: begin
            if (wb_sel_i[0]) r_cursor[7:0]    <= wb_dat_i[7:0];
            if (wb_sel_i[1]) r_cursor[CW-1:8] <= wb_dat_i[CW-1:8];
          end
          REG_PERIOD: begin
            if (wb_sel_i[0]) r_period <= wb_dat_i[7:0];
          end
          default: begin
            r_col     <= w_col_c;
            r_row     <= w_row_c;
            r_rc_pend <= 1'b1;
          end
        endcase
      end
    end
  end

  // Flash timebase: clock divider to ms ticks, ms counter toggles flash
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tick  <= '0;
      r_ms    <= 8'd0;
      r_flash <= 1'b1;
    end else if (w_wr && (w_reg == REG_PERIOD)) begin
      r_tick  <= '0;
      r_ms    <= 8'd0;
      r_flash <= 1'b1;
    end else begin
      r_tick <= w_tick ? '0 : r_tick + TW'(1);
      if (r_period == 8'd0) begin
        r_ms    <= 8'd0;
        r_flash <= 1'b1;
      end else if (w_tick) begin
        if (r_ms == r_period - 8'd1) begin
          r_ms    <= 8'd0;
          r_flash <= ~r_flash;
        end else begin
          r_ms <= r_ms + 8'd1;
        end
      end
    end
  end

  assign wb_ack_o    = r_ack;
  assign wb_dat_o    = r_dat;
  assign cursor      = r_cursor;
  assign lmode       = r_lmode;
  assign cursor_type = r_cursor_type;
  assign flash       = r_flash;
  assign cursor_on   = r_cursor_en & (~r_blink_en | r_flash);

endmodule
